// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Purpose: holds the program counter, fetches 32-bit instructions from
// instruction memory over a req/gnt/rvalid handshake (one outstanding request
// at most) and presents each one to the decoder with a valid/ready handshake.
// When the decoder accepts an instruction, its PCSel choice selects the next
// PC: PC+4 (wrapping) or the ALU branch/jump target. A misaligned next PC
// parks the unit in a terminal ERROR state with a sticky flag.
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds fetch_count and
// stall_cycles performance counters. Without the macro neither the counters
// nor their ports exist.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   imem_req       out  fetch request (high only in FETCH)
//   imem_addr      out  fetch address (equals pc)
//   imem_gnt       in   memory accepted the request
//   imem_rvalid    in   read data valid
//   imem_rdata     in   instruction word
//   Inst           out  current instruction
//   inst_valid     out  Inst/pc valid
//   inst_ready     in   decoder accepts Inst
//   PCSel          in   0: pc+4, 1: alu_target
//   alu_target     in   branch/jump target
//   pc             out  address of Inst
//   fetch_misalign out  sticky misaligned-target flag
//   fetch_count    out  (FETCH_PERF_CNT_EN) accepted instructions
//   stall_cycles   out  (FETCH_PERF_CNT_EN) FETCH/WAIT stall cycles
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              PCSel,
    input  logic [ADDR_W-1:0] alu_target,
    output logic [ADDR_W-1:0] pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_cycles,
`endif
    output logic              fetch_misalign
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t              state_q;
    logic                req_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [31:0]         inst_q;
    logic                valid_q;
    logic                misalign_q;

    logic [ADDR_W-1:0]   next_pc_d;
    logic                next_aligned_d;

    // Candidate next PC; pc+4 wraps naturally at the register width.
    always_comb begin
        next_pc_d = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};
        if (PCSel) begin
            next_pc_d = alu_target;
        end else begin
            next_pc_d = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};
        end
        next_aligned_d = (next_pc_d[1:0] == 2'b00);
    end

    // Fetch FSM with all outputs held in registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0000_0000;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    // Address stays on pc_q until the memory grants.
                    if (imem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        inst_q  <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (inst_ready) begin
                        valid_q <= 1'b0;
                        if (next_aligned_d) begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            // pc keeps the address of the offending instruction.
                            misalign_q <= 1'b1;
                            state_q    <= ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: drop everything and refetch pc.
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign Inst           = inst_q;
    assign inst_valid     = valid_q;
    assign fetch_misalign = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_cycles_q;

    // Performance counters: accepted instructions and memory stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q  <= 32'h0000_0000;
            stall_cycles_q <= 32'h0000_0000;
        end else begin
            if ((state_q == ST_DELIVER) && inst_ready) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (((state_q == ST_FETCH) && !imem_gnt) ||
                ((state_q == ST_WAIT) && !imem_rvalid)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign stall_cycles = stall_cycles_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a randomized memory and consumer
// drive the DUT on the falling edge; an independent monitor samples just
// after each rising edge and compares against the expected-fetch queue.
module tb_inst_fetch_unit;
    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic [31:0] Inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        PCSel = 1'b0;
    logic [31:0] alu_target = 32'h0000_0000;
    logic [31:0] pc;
    logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Inst(Inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .PCSel(PCSel), .alu_target(alu_target), .pc(pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count), .stall_cycles(stall_cycles),
`endif
        .fetch_misalign(fetch_misalign)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct packed { logic sel; logic [31:0] tgt; } choice_t;

    exp_t    exp_q[$];      // expected fetches, in program order
    choice_t force_q[$];    // directed decoder choices, used before random ones

    int checks_total  = 0;
    int checks_passed = 0;

    // reference model state
    logic [31:0] model_pc     = RESET_PC;
    logic        exp_valid    = 1'b0;
    logic        exp_misalign = 1'b0;
    int unsigned exp_fetch    = 0;
    int unsigned exp_stall    = 0;

    // memory / consumer environment state
    logic        pending    = 1'b0;
    logic [31:0] grant_addr = 32'h0000_0000;
    int          lat        = 0;
    int          lat_max    = 2;
    int          gnt_pct    = 70;
    int          ready_pct  = 70;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Decoder accepted the current instruction with choice c.
    task automatic model_accept(input choice_t c);
        logic [31:0] nxt;
        exp_t e;
        exp_fetch++;
        exp_valid = 1'b0;
        nxt = c.sel ? c.tgt : model_pc + 32'd4;
        if (nxt[1:0] == 2'b00) begin
            model_pc = nxt;
            e.pc = nxt;
            e.inst = mem_word(nxt);
            exp_q.push_back(e);
        end else begin
            exp_misalign = 1'b1;
        end
    endtask

    // Called on a falling edge: drive memory and decoder inputs, then wait one cycle.
    task automatic step();
        choice_t c;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        if (pending) begin
            imem_gnt = ($urandom_range(0, 3) == 0);
            if (lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(grant_addr);
                pending = 1'b0;
                exp_valid = 1'b1;
            end else begin
                lat--;
                exp_stall++;
            end
        end else begin
            imem_rvalid = ($urandom_range(0, 9) == 0);
            if (imem_req) begin
                if ($urandom_range(1, 100) <= gnt_pct) begin
                    imem_gnt = 1'b1;
                    pending = 1'b1;
                    grant_addr = imem_addr;
                    lat = $urandom_range(0, lat_max);
                end else begin
                    exp_stall++;
                end
            end else begin
                imem_gnt = ($urandom_range(0, 3) == 0);
            end
        end
        PCSel = $urandom_range(0, 1);
        alu_target = $urandom;
        if (inst_valid) begin
            if ($urandom_range(1, 100) <= ready_pct) begin
                inst_ready = 1'b1;
                if (force_q.size() > 0) begin
                    c = force_q.pop_front();
                end else begin
                    c.sel = ($urandom_range(0, 3) == 0);
                    c.tgt = c.sel ? ($urandom & 32'hFFFF_FFFC) : $urandom;
                end
                PCSel = c.sel;
                alu_target = c.tgt;
                model_accept(c);
            end else begin
                inst_ready = 1'b0;
            end
        end else begin
            inst_ready = $urandom_range(0, 1);
        end
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on a falling edge with the DUT in FETCH.
    task automatic apply_reset(input int hold);
        exp_t e;
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        PCSel = 1'b0; alu_target = 32'h0000_0000;
        exp_q.delete();
        pending = 1'b0; exp_valid = 1'b0; exp_misalign = 1'b0;
        exp_fetch = 0; exp_stall = 0;
        model_pc = RESET_PC;
        e.pc = RESET_PC; e.inst = mem_word(RESET_PC);
        exp_q.push_back(e);
        #1;
        check("rst_imem_req", imem_req, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", Inst, 32'h0000_0000);
        check("rst_inst_valid", inst_valid, 32'd0);
        check("rst_misalign", fetch_misalign, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        repeat (hold) @(negedge clk);
        reset = 1'b0;
        // stale response and stray grant during IDLE must be ignored
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; inst_ready = 1'b1;
        @(negedge clk);
        check("idle_then_fetch_req", imem_req, 32'd1);
    endtask

    // Monitor: compares DUT outputs with the scoreboard after every rising edge.
    initial begin : monitor
        logic prev_valid;
        exp_t cur;
        prev_valid = 1'b0;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                check("inst_valid", inst_valid, exp_valid);
                check("fetch_misalign", fetch_misalign, exp_misalign);
                if (pending) check("req_while_outstanding", imem_req, 32'd0);
                if (imem_req) begin
                    if (exp_q.size() == 0) check("req_without_target", imem_req, 32'd0);
                    else check("imem_addr", imem_addr, exp_q[0].pc);
                end
                if (inst_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("delivery_without_fetch", inst_valid, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("deliver_pc", pc, cur.pc);
                        check("deliver_inst", Inst, cur.inst);
                    end
                end else if (inst_valid) begin
                    check("hold_pc", pc, cur.pc);
                    check("hold_inst", Inst, cur.inst);
                end
`ifdef FETCH_PERF_CNT_EN
                check("fetch_count", fetch_count, exp_fetch);
                check("stall_cycles", stall_cycles, exp_stall);
`endif
                prev_valid = inst_valid;
            end
        end
    end

    initial begin : stimulus
        choice_t c;
        int n;
        @(negedge clk);
        apply_reset(2);

        // sequential fetch then a taken branch at pc=8 to 0x40
        gnt_pct = 100; ready_pct = 100; lat_max = 0;
        c.sel = 1'b0; c.tgt = 32'h0000_0003; force_q.push_back(c);
        c.sel = 1'b0; c.tgt = 32'h0000_0001; force_q.push_back(c);
        c.sel = 1'b1; c.tgt = 32'h0000_0040; force_q.push_back(c);
        c.sel = 1'b0; c.tgt = 32'h0000_0002; force_q.push_back(c);
        repeat (40) step();

        // heavy backpressure on both sides
        gnt_pct = 25; ready_pct = 15; lat_max = 3;
        repeat (300) step();

        // pc wrap from 0xFFFF_FFFC to 0
        gnt_pct = 80; ready_pct = 80; lat_max = 1;
        c.sel = 1'b1; c.tgt = 32'hFFFF_FFFC; force_q.push_back(c);
        c.sel = 1'b0; c.tgt = 32'h0000_0001; force_q.push_back(c);
        c.sel = 1'b0; c.tgt = 32'h0000_0002; force_q.push_back(c);
        repeat (60) step();

        // random traffic
        gnt_pct = 60; ready_pct = 60; lat_max = 2;
        repeat (1500) step();

        // reset while a response is outstanding
        n = 0;
        while (!pending && n < 100) begin step(); n++; end
        check("reached_wait", pending, 32'd1);
        apply_reset(2);
        repeat (60) step();

        // misaligned branch target parks the unit
        force_q.delete();
        c.sel = 1'b1; c.tgt = 32'h0000_0102; force_q.push_back(c);
        n = 0;
        while (!exp_misalign && n < 200) begin step(); n++; end
        check("misalign_taken", exp_misalign, 32'd1);
        gnt_pct = 100;
        repeat (12) begin
            step();
            check("no_req_in_error", imem_req, 32'd0);
            check("pc_hold_in_error", pc, model_pc);
        end

        apply_reset(3);
        gnt_pct = 60; ready_pct = 60;
        repeat (40) step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
